str_arb_rr: RTL



---
 rtl/str_arb_rr.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/str_arb_rr.sv
// Packet-granular round-robin arbiter: merges NB_UP valid/ready/last streams into one registered stream.
// Optional macro STR_ARB_RR_PRIO_EN: requester 0 wins arbitration whenever it is requesting.
module str_arb_rr #(
    parameter int  NB_UP      = 4,
    parameter int  DATA_WIDTH = 8,
    localparam int SEL_WIDTH  = (NB_UP > 1) ? $clog2(NB_UP) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NB_UP*DATA_WIDTH-1:0] up_data,
    input  logic [NB_UP-1:0]            up_last,
    input  logic [NB_UP-1:0]            up_val,
    output logic [NB_UP-1:0]            up_rdy,
    output logic [DATA_WIDTH-1:0]       dn_data,
    output logic                        dn_last,
    output logic                        dn_val,
    input  logic                        dn_rdy,
    output logic [SEL_WIDTH-1:0]        dn_sel
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SEL_WIDTH-1:0]   r_gnt;
    logic [SEL_WIDTH-1:0]   w_gnt_next;
    logic [SEL_WIDTH-1:0]   r_ptr;
    logic [SEL_WIDTH-1:0]   w_ptr_next;

    logic [DATA_WIDTH-1:0]  r_dn_data;
    logic                   r_dn_last;
    logic                   r_dn_val;
    logic [SEL_WIDTH-1:0]   r_dn_sel;

    logic [NB_UP-1:0]       w_gnt_oh;
    logic [SEL_WIDTH-1:0]   w_dist [NB_UP];
    logic [NB_UP-1:0]       w_rr_win;
    logic [DATA_WIDTH-1:0]  w_gnt_data;
    logic                   w_gnt_val;
    logic                   w_gnt_last;
    logic                   w_dn_active;
    logic                   w_xfer;
    logic                   w_any_req;
    logic [SEL_WIDTH-1:0]   w_pick_idx;
    logic                   w_pick_upd_ptr;

    // Per-requester logic: grant decode, search distance from ptr, winner and
    // one-hot-to-index / data-mux reductions built as chained OR terms.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NB_UP; gi++) begin : g_req
            logic [NB_UP-1:0]      w_closer;
            logic [SEL_WIDTH-1:0]  w_idx_term;
            logic [SEL_WIDTH-1:0]  w_idx_acc;
            logic [DATA_WIDTH-1:0] w_data_term;
            logic [DATA_WIDTH-1:0] w_data_acc;

            assign w_gnt_oh[gi] = (r_gnt == SEL_WIDTH'(gi));
            // Distance 0 is ptr+1, so the search order is ptr+1, ptr+2, ... with wrap.
            assign w_dist[gi]   = SEL_WIDTH'((gi + 2*NB_UP - 1 - int'(r_ptr)) % NB_UP);

            for (gj = 0; gj < NB_UP; gj++) begin : g_cmp
                assign w_closer[gj] = up_val[gj] && (w_dist[gj] < w_dist[gi]);
            end

            assign w_rr_win[gi] = up_val[gi] && !(|w_closer);
            assign w_idx_term   = w_rr_win[gi] ? SEL_WIDTH'(gi) : '0;
            assign w_data_term  = w_gnt_oh[gi] ? up_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

            if (gi == 0) begin : g_first
                assign w_idx_acc  = w_idx_term;
                assign w_data_acc = w_data_term;
            end else begin : g_rest
                assign w_idx_acc  = g_req[gi-1].w_idx_acc | w_idx_term;
                assign w_data_acc = g_req[gi-1].w_data_acc | w_data_term;
            end
        end
    endgenerate

    assign w_gnt_data  = g_req[NB_UP-1].w_data_acc;
    assign w_gnt_val   = |(up_val & w_gnt_oh);
    assign w_gnt_last  = |(up_last & w_gnt_oh);
    assign w_any_req   = |up_val;
    assign w_dn_active = ~r_dn_val | dn_rdy;
    assign w_xfer      = (r_state == ST_LOCK) && w_dn_active && w_gnt_val;

    always_comb begin
        w_pick_idx     = g_req[NB_UP-1].w_idx_acc;
        w_pick_upd_ptr = 1'b1;
`ifdef STR_ARB_RR_PRIO_EN
        // Requester 0 overrides the rotation and does not advance the pointer.
        if (up_val[0]) begin
            w_pick_idx     = '0;
            w_pick_upd_ptr = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= SEL_WIDTH'(NB_UP - 1);
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ST_LOCK;
                    w_gnt_next   = w_pick_idx;
                    if (w_pick_upd_ptr) begin
                        w_ptr_next = w_pick_idx;
                    end
                end
            end
            ST_LOCK: begin
                // Release only on the accepted last beat; this forces one IDLE bubble.
                if (w_xfer && w_gnt_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        up_rdy = '0;
        if (r_state == ST_LOCK && w_dn_active) begin
            up_rdy = w_gnt_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dn_val  <= 1'b0;
            r_dn_last <= 1'b0;
            r_dn_data <= '0;
            r_dn_sel  <= '0;
        end else if (w_dn_active) begin
            r_dn_val <= w_xfer;
            if (w_xfer) begin
                r_dn_data <= w_gnt_data;
                r_dn_last <= w_gnt_last;
                r_dn_sel  <= r_gnt;
            end
        end
    end

    assign dn_data = r_dn_data;
    assign dn_last = r_dn_last;
    assign dn_val  = r_dn_val;
    assign dn_sel  = r_dn_sel;

endmodule
